// File: rtl/alu_mux_pkg.sv
// Shared definitions for the ALU operand selector: default sizes, named
// select codes for the ID/EX operand mux, and a select range helper.
package alu_mux_pkg;

   localparam int ALU_MUX_WIDTH_DFLT = 32;
   localparam int ALU_MUX_NIN_DFLT   = 4;
   localparam int ALU_MUX_SEL_W      = $clog2(ALU_MUX_NIN_DFLT);

   typedef logic [ALU_MUX_SEL_W-1:0] alu_sel_t;

   localparam alu_sel_t SEL_REG     = alu_sel_t'(0);
   localparam alu_sel_t SEL_IMM     = alu_sel_t'(1);
   localparam alu_sel_t SEL_FWD_EX  = alu_sel_t'(2);
   localparam alu_sel_t SEL_FWD_MEM = alu_sel_t'(3);

   // True when a select code addresses no physical input.
   function automatic logic sel_oob(input int sel, input int num_in);
      return (sel >= num_in);
   endfunction

endpackage

// File: rtl/alu_mux_comb.sv
// Purely combinational N:1 operand mux. A select that addresses no input
// (possible when NUM_IN is not a power of 2) falls back to input 0.
module alu_mux_comb
   import alu_mux_pkg::*;
#(
   parameter int WIDTH  = ALU_MUX_WIDTH_DFLT,
   parameter int NUM_IN = ALU_MUX_NIN_DFLT,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        out_data
);

   // Input 0 is the default; any matching in-range index overrides it.
   always_comb begin
      out_data = in_data[WIDTH-1:0];
      for (int k = 1; k < NUM_IN; k++) begin
         if (int'(sel) == k) out_data = in_data[k*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/alu_operand_mux_reg.sv
// ID/EX operand selector: N:1 mux followed by a single registered output
// stage with valid/ready handshake, stall (out_ready low) and flush.
// Optional build macro ALU_MUX_SELCHK_EN adds a sticky out-of-range select
// flag on sel_err; without it sel_err is tied low and no check exists.
module alu_operand_mux_reg
   import alu_mux_pkg::*;
#(
   parameter int WIDTH  = ALU_MUX_WIDTH_DFLT,
   parameter int NUM_IN = ALU_MUX_NIN_DFLT,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    sel_err
);

   logic             accept_p0;
   logic [WIDTH-1:0] data_p0;
   logic             vld_p1;
   logic [WIDTH-1:0] data_p1;
   logic [SEL_W-1:0] sel_p1;

   // ---- stage p0: select and handshake (combinational) ----
   alu_mux_comb #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_mux (
      .in_data  (in_data),
      .sel      (in_sel),
      .out_data (data_p0)
   );

   // The slot can take a new operand when empty or being drained, never during flush.
   assign in_ready  = !flush && (!vld_p1 || out_ready);
   assign accept_p0 = in_valid && in_ready;

   // ---- stage p1: registered operand ----
   // Occupancy: fill on accept, empty on flush or on drain without refill.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else if (accept_p0) begin
         vld_p1 <= 1'b1;
      end else if (flush || out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   // Operand and its select code load only on accept and hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_p1 <= '0;
         sel_p1  <= '0;
      end else if (accept_p0) begin
         data_p1 <= data_p0;
         sel_p1  <= in_sel;
      end
   end

`ifdef ALU_MUX_SELCHK_EN
   logic err_p1;

   // Sticky flag: set by an accepted out-of-range select, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_p1 <= 1'b0;
      end else if (accept_p0 && sel_oob(int'(in_sel), NUM_IN)) begin
         err_p1 <= 1'b1;
      end
   end

   assign sel_err = err_p1;
`else
   assign sel_err = 1'b0;
`endif

   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign out_sel   = sel_p1;

endmodule
